// File: rtl/ibex_irq_ctrl.sv
// Interrupt source for the Ibex core: prescaled mtime/mtimecmp timer, software, external, fast and NMI lanes.
// Bus responses arrive one cycle after each request; external/fast/NMI inputs reach outputs after 1 cycle (3 with sync).
// No backpressure: every request is granted in its own cycle. Define IBEX_IRQ_CTRL_SYNC_EN for input synchronisers.
module ibex_irq_ctrl #(
    parameter int NumFast   = 15,
    parameter int PrescaleW = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               data_req_i,
    input  logic               data_we_i,
    input  logic [3:0]         data_be_i,
    input  logic [31:0]        data_addr_i,
    input  logic [31:0]        data_wdata_i,
    output logic               data_gnt_o,
    output logic               data_rvalid_o,
    output logic [31:0]        data_rdata_o,
    output logic               data_err_o,

    input  logic [NumFast-1:0] fast_evt_i,
    input  logic               ext_irq_i,
    input  logic               nmi_evt_i,

    output logic               irq_software_o,
    output logic               irq_timer_o,
    output logic               irq_external_o,
    output logic [14:0]        irq_fast_o,
    output logic               irq_nm_o
);

    // Word offsets within the register window (addr[5:2]).
    localparam logic [3:0] IdxMtimeLo    = 4'd0;
    localparam logic [3:0] IdxMtimeHi    = 4'd1;
    localparam logic [3:0] IdxMtimecmpLo = 4'd2;
    localparam logic [3:0] IdxMtimecmpHi = 4'd3;
    localparam logic [3:0] IdxMsip       = 4'd4;
    localparam logic [3:0] IdxFastPend   = 4'd5;
    localparam logic [3:0] IdxFastEn     = 4'd6;
    localparam logic [3:0] IdxPrescale   = 4'd7;
    localparam logic [3:0] IdxNmiPend    = 4'd8;

    // Register state.
    logic [63:0]          mtime;
    logic [63:0]          mtimecmp;
    logic                 msip;
    logic [NumFast-1:0]   fast_pend;
    logic [NumFast-1:0]   fast_en;
    logic [PrescaleW-1:0] prescale;
    logic [PrescaleW-1:0] presc_cnt;
    logic                 nmi_pend;

    // Edge detect / registered irq state.
    logic [NumFast-1:0]   fast_evt_q;
    logic                 nmi_evt_q;
    logic                 ext_q;
    logic                 timer_q;

    // Response pipeline.
    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic                 err_q;

    // Bus decode.
    logic [3:0]           reg_idx;
    logic                 wr_en;
    logic                 rd_en;
    logic [31:0]          wmask;
    logic [31:0]          rd_val;
    logic                 bad_idx;
    logic                 unused_addr;

    assign reg_idx     = data_addr_i[5:2];
    assign wr_en       = data_req_i & data_we_i;
    assign rd_en       = data_req_i & ~data_we_i;
    assign wmask       = {{8{data_be_i[3]}}, {8{data_be_i[2]}}, {8{data_be_i[1]}}, {8{data_be_i[0]}}};
    assign unused_addr = ^{data_addr_i[31:6], data_addr_i[1:0]};

    logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
    logic wr_msip, wr_fast_pend, wr_fast_en, wr_prescale, wr_nmi_pend;

    assign wr_mtime_lo  = wr_en && (reg_idx == IdxMtimeLo);
    assign wr_mtime_hi  = wr_en && (reg_idx == IdxMtimeHi);
    assign wr_cmp_lo    = wr_en && (reg_idx == IdxMtimecmpLo);
    assign wr_cmp_hi    = wr_en && (reg_idx == IdxMtimecmpHi);
    assign wr_msip      = wr_en && (reg_idx == IdxMsip);
    assign wr_fast_pend = wr_en && (reg_idx == IdxFastPend);
    assign wr_fast_en   = wr_en && (reg_idx == IdxFastEn);
    assign wr_prescale  = wr_en && (reg_idx == IdxPrescale);
    assign wr_nmi_pend  = wr_en && (reg_idx == IdxNmiPend);

    // Read mux: current register values, unimplemented bits zero.
    always_comb begin
        rd_val  = 32'd0;
        bad_idx = 1'b0;
        case (reg_idx)
            IdxMtimeLo:    rd_val = mtime[31:0];
            IdxMtimeHi:    rd_val = mtime[63:32];
            IdxMtimecmpLo: rd_val = mtimecmp[31:0];
            IdxMtimecmpHi: rd_val = mtimecmp[63:32];
            IdxMsip:       rd_val = {31'd0, msip};
            IdxFastPend:   rd_val = 32'(fast_pend);
            IdxFastEn:     rd_val = 32'(fast_en);
            IdxPrescale:   rd_val = 32'(prescale);
            IdxNmiPend:    rd_val = {31'd0, nmi_pend};
            default:       bad_idx = 1'b1;
        endcase
    end

    // Grant is withheld while reset is asserted so every output is quiet in reset.
    assign data_gnt_o    = data_req_i & ~rst_i;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;

    // One-cycle response: capture read data and error flag from the request cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= data_req_i;
            rdata_q  <= rd_en ? rd_val : 32'd0;
            err_q    <= data_req_i & bad_idx;
        end
    end

    // Input conditioning: optional 2-flop synchronisers ahead of edge detection.
    logic [NumFast-1:0] fast_in;
    logic               ext_in;
    logic               nmi_in;

`ifdef IBEX_IRQ_CTRL_SYNC_EN
    logic [NumFast-1:0] fast_s1, fast_s2;
    logic               ext_s1, ext_s2;
    logic               nmi_s1, nmi_s2;

    // Two-stage synchronisers for the asynchronous event inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fast_s1 <= '0;
            fast_s2 <= '0;
            ext_s1  <= 1'b0;
            ext_s2  <= 1'b0;
            nmi_s1  <= 1'b0;
            nmi_s2  <= 1'b0;
        end else begin
            fast_s1 <= fast_evt_i;
            fast_s2 <= fast_s1;
            ext_s1  <= ext_irq_i;
            ext_s2  <= ext_s1;
            nmi_s1  <= nmi_evt_i;
            nmi_s2  <= nmi_s1;
        end
    end

    assign fast_in = fast_s2;
    assign ext_in  = ext_s2;
    assign nmi_in  = nmi_s2;
`else
    assign fast_in = fast_evt_i;
    assign ext_in  = ext_irq_i;
    assign nmi_in  = nmi_evt_i;
`endif

    // Prescaler: tick when the counter reaches PRESCALE; a PRESCALE write restarts it.
    logic tick;
    assign tick = (presc_cnt == prescale);

    // Prescale counter and PRESCALE register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_cnt <= '0;
            prescale  <= '0;
        end else begin
            if (wr_prescale) begin
                prescale  <= (prescale & ~wmask[PrescaleW-1:0]) |
                             (data_wdata_i[PrescaleW-1:0] & wmask[PrescaleW-1:0]);
                presc_cnt <= '0;
            end else if (tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    // mtime: a bus write to either half takes priority over (and swallows) the tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime <= 64'd0;
        end else if (wr_mtime_lo) begin
            mtime[31:0]  <= (mtime[31:0] & ~wmask) | (data_wdata_i & wmask);
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= (mtime[63:32] & ~wmask) | (data_wdata_i & wmask);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp halves and the software interrupt bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (wr_cmp_lo) begin
                mtimecmp[31:0]  <= (mtimecmp[31:0] & ~wmask) | (data_wdata_i & wmask);
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= (mtimecmp[63:32] & ~wmask) | (data_wdata_i & wmask);
            end
            if (wr_msip && data_be_i[0]) begin
                msip <= data_wdata_i[0];
            end
        end
    end

    // Timer interrupt is the registered unsigned compare result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= 1'b0;
        end else begin
            timer_q <= (mtime >= mtimecmp);
        end
    end

    // Fast and NMI capture: rising edges set pending, W1C clears, set wins on collision.
    logic [NumFast-1:0] fast_rise;
    logic [NumFast-1:0] fast_w1c;
    logic               nmi_rise;
    logic               nmi_w1c;

    assign fast_rise = fast_in & ~fast_evt_q;
    assign fast_w1c  = wr_fast_pend ? (data_wdata_i[NumFast-1:0] & wmask[NumFast-1:0]) : '0;
    assign nmi_rise  = nmi_in & ~nmi_evt_q;
    assign nmi_w1c   = wr_nmi_pend & data_be_i[0] & data_wdata_i[0];

    // Pending/enable latches, edge-detect history and the external level register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fast_evt_q <= '0;
            fast_pend  <= '0;
            fast_en    <= '0;
            nmi_evt_q  <= 1'b0;
            nmi_pend   <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            fast_evt_q <= fast_in;
            fast_pend  <= (fast_pend & ~fast_w1c) | fast_rise;
            if (wr_fast_en) begin
                fast_en <= (fast_en & ~wmask[NumFast-1:0]) |
                           (data_wdata_i[NumFast-1:0] & wmask[NumFast-1:0]);
            end
            nmi_evt_q  <= nmi_in;
            nmi_pend   <= (nmi_pend & ~nmi_w1c) | nmi_rise;
            ext_q      <= ext_in;
        end
    end

    // Fast lanes beyond NumFast are tied off.
    always_comb begin
        irq_fast_o              = 15'd0;
        irq_fast_o[NumFast-1:0] = fast_pend & fast_en;
    end

    assign irq_software_o = msip;
    assign irq_timer_o    = timer_q;
    assign irq_external_o = ext_q;
    assign irq_nm_o       = nmi_pend;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Directed bench for ibex_irq_ctrl: register table, timer compare, fast/NMI capture, reset.
module tb_ibex_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'd0;
    logic [31:0] data_wdata_i = 32'd0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [14:0] fast_evt_i = 15'd0;
    logic        ext_irq_i = 1'b0;
    logic        nmi_evt_i = 1'b0;
    logic        irq_software_o;
    logic        irq_timer_o;
    logic        irq_external_o;
    logic [14:0] irq_fast_o;
    logic        irq_nm_o;

    ibex_irq_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .fast_evt_i     (fast_evt_i),
        .ext_irq_i      (ext_irq_i),
        .nmi_evt_i      (nmi_evt_i),
        .irq_software_o (irq_software_o),
        .irq_timer_o    (irq_timer_o),
        .irq_external_o (irq_external_o),
        .irq_fast_o     (irq_fast_o),
        .irq_nm_o       (irq_nm_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // One bus access starting at posedge+1; returns at the next posedge+1 with the response.
    task automatic bus(input logic we, input logic [3:0] off, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = {26'd0, off, 2'b00};
        data_wdata_i = wd;
        data_be_i    = be;
        #1;
        chk("gnt", {63'd0, data_gnt_o}, 64'd1);
        @(posedge clk_i); #1;
        chk("rvalid", {63'd0, data_rvalid_o}, 64'd1);
        rd = data_rdata_o;
        er = data_err_o;
        data_req_i = 1'b0;
        data_we_i  = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  off;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[30];

    logic [31:0] rd;
    logic        er;
    logic [31:0] m[100];
    logic        t[100];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        // Reset reads first (mtime sampled in the first cycle after release is 0), then field behaviour.
        vt[0]  = '{1'b0, 4'd0,  32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b0, 4'd1,  32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vt[2]  = '{1'b0, 4'd2,  32'h0,        4'hF, 32'hFFFF_FFFF, 1'b0};
        vt[3]  = '{1'b0, 4'd3,  32'h0,        4'hF, 32'hFFFF_FFFF, 1'b0};
        vt[4]  = '{1'b0, 4'd4,  32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vt[5]  = '{1'b0, 4'd5,  32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vt[6]  = '{1'b0, 4'd6,  32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vt[7]  = '{1'b0, 4'd7,  32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vt[8]  = '{1'b0, 4'd8,  32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vt[9]  = '{1'b0, 4'd9,  32'h0,        4'hF, 32'h0000_0000, 1'b1};
        vt[10] = '{1'b0, 4'd15, 32'h0,        4'hF, 32'h0000_0000, 1'b1};
        vt[11] = '{1'b1, 4'd1,  32'hAABBCCDD, 4'h5, 32'h0,         1'b0};
        vt[12] = '{1'b0, 4'd1,  32'h0,        4'hF, 32'h00BB_00DD, 1'b0};
        vt[13] = '{1'b1, 4'd1,  32'h0,        4'hF, 32'h0,         1'b0};
        vt[14] = '{1'b1, 4'd6,  32'hFFFF_FFFF, 4'hF, 32'h0,        1'b0};
        vt[15] = '{1'b0, 4'd6,  32'h0,        4'hF, 32'h0000_7FFF, 1'b0};
        vt[16] = '{1'b1, 4'd6,  32'h0,        4'hF, 32'h0,         1'b0};
        vt[17] = '{1'b1, 4'd7,  32'h0000_01FF, 4'hF, 32'h0,        1'b0};
        vt[18] = '{1'b0, 4'd7,  32'h0,        4'hF, 32'h0000_00FF, 1'b0};
        vt[19] = '{1'b1, 4'd7,  32'h0000_0012, 4'h0, 32'h0,        1'b0};
        vt[20] = '{1'b0, 4'd7,  32'h0,        4'hF, 32'h0000_00FF, 1'b0};
        vt[21] = '{1'b1, 4'd7,  32'h0,        4'hF, 32'h0,         1'b0};
        vt[22] = '{1'b1, 4'd4,  32'hFFFF_FFFF, 4'h1, 32'h0,        1'b0};
        vt[23] = '{1'b0, 4'd4,  32'h0,        4'hF, 32'h0000_0001, 1'b0};
        vt[24] = '{1'b1, 4'd4,  32'h0,        4'hF, 32'h0,         1'b0};
        vt[25] = '{1'b1, 4'd5,  32'hFFFF_FFFF, 4'hF, 32'h0,        1'b0};
        vt[26] = '{1'b0, 4'd5,  32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vt[27] = '{1'b1, 4'd10, 32'h1234_5678, 4'hF, 32'h0,        1'b1};
        vt[28] = '{1'b1, 4'd2,  32'h1234_5678, 4'h3, 32'h0,        1'b0};
        vt[29] = '{1'b0, 4'd2,  32'h0,        4'hF, 32'hFFFF_5678, 1'b0};

        // Quiet outputs while in reset.
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("reset rvalid", {63'd0, data_rvalid_o}, 64'd0);
        chk("reset rdata", {32'd0, data_rdata_o}, 64'd0);
        chk("reset irqs", {45'd0, irq_software_o, irq_timer_o, irq_external_o, irq_fast_o, irq_nm_o}, 64'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 30; i++) begin
            bus(vt[i].we, vt[i].off, vt[i].wd, vt[i].be, rd, er);
            if (!vt[i].we) chk($sformatf("tbl%0d rdata", i), {32'd0, rd}, {32'd0, vt[i].exp_rd});
            chk($sformatf("tbl%0d err", i), {63'd0, er}, {63'd0, vt[i].exp_err});
        end
        chk("timer idle after reset", {63'd0, irq_timer_o}, 64'd0);
        bus(1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, rd, er);

        // rvalid is a single-cycle pulse and rdata idles at zero.
        @(posedge clk_i); #1;
        chk("rvalid idle", {63'd0, data_rvalid_o}, 64'd0);
        chk("rdata idle", {32'd0, data_rdata_o}, 64'd0);

        // Software interrupt follows MSIP.
        bus(1'b1, 4'd4, 32'h1, 4'hF, rd, er);
        chk("msip irq set", {63'd0, irq_software_o}, 64'd1);
        bus(1'b1, 4'd4, 32'h0, 4'hF, rd, er);
        chk("msip irq clr", {63'd0, irq_software_o}, 64'd0);

        // Timer: prescale 3, compare at 10, sample mtime and irq_timer every cycle.
        bus(1'b1, 4'd7, 32'd3, 4'hF, rd, er);
        bus(1'b1, 4'd0, 32'd0, 4'hF, rd, er);
        bus(1'b1, 4'd1, 32'd0, 4'hF, rd, er);
        bus(1'b1, 4'd3, 32'd0, 4'hF, rd, er);
        bus(1'b1, 4'd2, 32'd10, 4'hF, rd, er);
        for (int i = 0; i < 100; i++) begin
            t[i] = irq_timer_o;
            bus(1'b0, 4'd0, 32'd0, 4'hF, rd, er);
            m[i] = rd;
        end
        begin
            int k10, k5, k6;
            k10 = -1; k5 = -1; k6 = -1;
            for (int i = 0; i < 100; i++) begin
                if (k10 < 0 && m[i] == 32'd10) k10 = i;
                if (k5 < 0 && m[i] == 32'd5) k5 = i;
                if (k6 < 0 && m[i] == 32'd6) k6 = i;
            end
            chk("mtime reaches 10", {63'd0, (k10 >= 1 && k10 < 99)}, 64'd1);
            chk("mtime step 4 cycles", 64'(k6 - k5), 64'd4);
            if (k10 >= 1 && k10 < 99) begin
                chk("timer low at mtime=10", {63'd0, t[k10]}, 64'd0);
                chk("timer high next cycle", {63'd0, t[k10+1]}, 64'd1);
            end
        end
        bus(1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("timer still high at write", {63'd0, irq_timer_o}, 64'd1);
        @(posedge clk_i); #1;
        chk("timer drops after cmp write", {63'd0, irq_timer_o}, 64'd0);

        // Fast edge capture with enable 0x5.
        bus(1'b1, 4'd6, 32'h5, 4'hF, rd, er);
        fast_evt_i = 15'h0003;
        @(posedge clk_i); #1;
        fast_evt_i = 15'h0000;
        chk("fast irq after pulse", {49'd0, irq_fast_o}, 64'h1);
        bus(1'b1, 4'd5, 32'h2, 4'hF, rd, er);
        bus(1'b0, 4'd5, 32'h0, 4'hF, rd, er);
        chk("fast pend after w1c bit1", {32'd0, rd}, 64'h1);
        bus(1'b1, 4'd5, 32'h1, 4'hF, rd, er);
        chk("fast irq cleared", {49'd0, irq_fast_o}, 64'h0);

        // Set wins when a rise and W1C hit bit0 in the same cycle.
        fast_evt_i = 15'h0001;
        @(posedge clk_i); #1;
        fast_evt_i = 15'h0000;
        @(posedge clk_i); #1;
        fast_evt_i = 15'h0001;
        bus(1'b1, 4'd5, 32'h1, 4'hF, rd, er);
        fast_evt_i = 15'h0000;
        chk("set wins irq", {49'd0, irq_fast_o}, 64'h1);
        bus(1'b0, 4'd5, 32'h0, 4'hF, rd, er);
        chk("set wins pend", {32'd0, rd}, 64'h1);
        bus(1'b1, 4'd5, 32'h1, 4'hF, rd, er);

        // Held-high input does not re-arm after a clear.
        fast_evt_i = 15'h0004;
        @(posedge clk_i); #1;
        chk("held input irq", {49'd0, irq_fast_o}, 64'h4);
        bus(1'b1, 4'd5, 32'h4, 4'hF, rd, er);
        bus(1'b0, 4'd5, 32'h0, 4'hF, rd, er);
        chk("held input no reset", {32'd0, rd}, 64'h0);
        fast_evt_i = 15'h0000;

        // Disabling masks the lane but keeps pending.
        fast_evt_i = 15'h0001;
        @(posedge clk_i); #1;
        fast_evt_i = 15'h0000;
        bus(1'b1, 4'd6, 32'h0, 4'hF, rd, er);
        chk("disabled lane masked", {49'd0, irq_fast_o}, 64'h0);
        bus(1'b0, 4'd5, 32'h0, 4'hF, rd, er);
        chk("disabled keeps pend", {32'd0, rd}, 64'h1);
        bus(1'b1, 4'd5, 32'h1, 4'hF, rd, er);

        // NMI capture and clear.
        nmi_evt_i = 1'b1;
        @(posedge clk_i); #1;
        nmi_evt_i = 1'b0;
        chk("nmi irq", {63'd0, irq_nm_o}, 64'd1);
        bus(1'b0, 4'd8, 32'h0, 4'hF, rd, er);
        chk("nmi pend read", {32'd0, rd}, 64'd1);
        bus(1'b1, 4'd8, 32'h1, 4'hF, rd, er);
        chk("nmi cleared", {63'd0, irq_nm_o}, 64'd0);

        // External level, one cycle of latency.
        ext_irq_i = 1'b1;
        #1;
        chk("ext not yet", {63'd0, irq_external_o}, 64'd0);
        @(posedge clk_i); #1;
        chk("ext high", {63'd0, irq_external_o}, 64'd1);
        ext_irq_i = 1'b0;
        @(posedge clk_i); #1;
        chk("ext low", {63'd0, irq_external_o}, 64'd0);

        // Async reset in the middle of a read request.
        bus(1'b1, 4'd4, 32'h1, 4'hF, rd, er);
        nmi_evt_i = 1'b1;
        @(posedge clk_i); #1;
        nmi_evt_i = 1'b0;
        chk("pre-reset nmi", {63'd0, irq_nm_o}, 64'd1);
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h8;
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid reset gnt", {63'd0, data_gnt_o}, 64'd0);
        chk("mid reset rvalid", {63'd0, data_rvalid_o}, 64'd0);
        chk("mid reset irqs", {45'd0, irq_software_o, irq_timer_o, irq_external_o, irq_fast_o, irq_nm_o}, 64'd0);
        @(posedge clk_i); #1;
        chk("no rvalid after reset", {63'd0, data_rvalid_o}, 64'd0);
        data_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        bus(1'b0, 4'd4, 32'h0, 4'hF, rd, er);
        chk("msip after reset", {32'd0, rd}, 64'd0);
        bus(1'b0, 4'd2, 32'h0, 4'hF, rd, er);
        chk("cmp after reset", {32'd0, rd}, 64'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
